// File: rtl/pll_lock_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// pll_lock_sequencer: rPLL reset sequencing, lock qualification with retry,
// and PSDA/DUTYDA update handshake.                            Rev 1.0
// ==========================================================================
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_STABLE   = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int MAX_RETRY     = 3,
  parameter int SETTLE_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda,
  input  logic       cfg_req,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  output logic       cfg_ack,
  input  logic       relock_req,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_PARAM = max2(max2(max2(RST_CYCLES, LOCK_STABLE),
                                       max2(LOCK_TIMEOUT, SETTLE_CYCLES)),
                                  MAX_RETRY);
  localparam int CW = $clog2(MAX_PARAM + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]    RETRY_LIMIT  = 2'(MAX_RETRY);
  localparam logic [3:0]    PSDA_RST     = 4'b0000;
  localparam logic [3:0]    DUTYDA_RST   = 4'b1000;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    RUN       = 3'd2,
    ADJUST    = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        state;
  logic          lock_meta;
  logic          lock_s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] stable_cnt;
  logic          req_armed;
  logic          accept;
  logic          abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  assign accept = (state == RUN) && !relock_req && lock_s && cfg_req && req_armed;
  assign abort  = (state == ADJUST) && (relock_req || !lock_s);

  // An aborted transaction never got its ack, so the still-waiting requester
  // is allowed to be served again once the PLL is back in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_armed <= 1'b1;
    end else if (accept) begin
      req_armed <= 1'b0;
    end else if (abort) begin
      req_armed <= 1'b1;
    end else if (state != ADJUST && !cfg_req) begin
      req_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_PLL;
      cnt        <= '0;
      stable_cnt <= '0;
      pll_reset  <= 1'b1;
      sys_rst_n  <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      cfg_ack    <= 1'b0;
      retry_cnt  <= 2'd0;
      pll_psda   <= PSDA_RST;
      pll_dutyda <= DUTYDA_RST;
    end else begin
      cfg_ack <= 1'b0;
      if (relock_req) begin
        state      <= RESET_PLL;
        cnt        <= '0;
        stable_cnt <= '0;
        pll_reset  <= 1'b1;
        sys_rst_n  <= 1'b0;
        locked     <= 1'b0;
        fault      <= 1'b0;
        retry_cnt  <= 2'd0;
      end else begin
        case (state)
          RESET_PLL: begin
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            if (cnt == RST_LAST) begin
              state      <= WAIT_LOCK;
              cnt        <= '0;
              stable_cnt <= '0;
              pll_reset  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end

          WAIT_LOCK: begin
            // Leave when this high sample brings the run length to LOCK_STABLE.
            if (lock_s && stable_cnt == STABLE_LAST) begin
              state      <= RUN;
              cnt        <= '0;
              stable_cnt <= '0;
              locked     <= 1'b1;
              sys_rst_n  <= 1'b1;
              retry_cnt  <= 2'd0;
            end else if (cnt == TIMEOUT_LAST) begin
              cnt        <= '0;
              stable_cnt <= '0;
              pll_reset  <= 1'b1;
              if (retry_cnt == RETRY_LIMIT) begin
                state <= FAULT;
                fault <= 1'b1;
              end else begin
                state     <= RESET_PLL;
                retry_cnt <= retry_cnt + 2'd1;
              end
            end else begin
              cnt        <= cnt + CW'(1);
              stable_cnt <= lock_s ? stable_cnt + CW'(1) : '0;
            end
          end

          RUN: begin
            if (!lock_s) begin
              state      <= RESET_PLL;
              cnt        <= '0;
              stable_cnt <= '0;
              pll_reset  <= 1'b1;
              sys_rst_n  <= 1'b0;
              locked     <= 1'b0;
            end else if (accept) begin
              state      <= ADJUST;
              cnt        <= '0;
              pll_psda   <= cfg_psda;
              pll_dutyda <= cfg_dutyda;
            end
          end

          ADJUST: begin
            if (!lock_s) begin
              state      <= RESET_PLL;
              cnt        <= '0;
              stable_cnt <= '0;
              pll_reset  <= 1'b1;
              sys_rst_n  <= 1'b0;
              locked     <= 1'b0;
            end else if (cnt == SETTLE_LAST) begin
              state   <= RUN;
              cnt     <= '0;
              cfg_ack <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end

          FAULT: begin
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            fault     <= 1'b1;
          end

          default: begin
            state      <= RESET_PLL;
            cnt        <= '0;
            stable_cnt <= '0;
            pll_reset  <= 1'b1;
            sys_rst_n  <= 1'b0;
            locked     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for pll_lock_sequencer: randomized lock/cfg timing checked against
// an arithmetic timing model of the lock, retry and handshake rules.
module tb_pll_lock_sequencer;

  localparam int RST     = 16;
  localparam int STABLE  = 64;
  localparam int TIMEOUT = 512;
  localparam int RETRY   = 3;
  localparam int SETTLE  = 32;
  localparam int ATTEMPT = RST + TIMEOUT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_reset;
  logic [3:0] pll_psda;
  logic [3:0] pll_dutyda;
  logic       cfg_req;
  logic [3:0] cfg_psda;
  logic [3:0] cfg_dutyda;
  logic       cfg_ack;
  logic       relock_req;
  logic       sys_rst_n;
  logic       locked;
  logic       fault;
  logic [1:0] retry_cnt;

  pll_lock_sequencer #(
    .RST_CYCLES   (RST),
    .LOCK_STABLE  (STABLE),
    .LOCK_TIMEOUT (TIMEOUT),
    .MAX_RETRY    (RETRY),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_psda   (pll_psda),
    .pll_dutyda (pll_dutyda),
    .cfg_req    (cfg_req),
    .cfg_psda   (cfg_psda),
    .cfg_dutyda (cfg_dutyda),
    .cfg_ack    (cfg_ack),
    .relock_req (relock_req),
    .sys_rst_n  (sys_rst_n),
    .locked     (locked),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [3:0] model_psda;
  logic [3:0] model_dutyda;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_reset"}, pll_reset, 1);
    check({tag, "_sys_rst_n"}, sys_rst_n, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_cfg_ack"}, cfg_ack, 0);
    check({tag, "_retry_cnt"}, retry_cnt, 0);
    check({tag, "_psda"}, pll_psda, 4'b0000);
    check({tag, "_dutyda"}, pll_dutyda, 4'b1000);
  endtask

  // Lock-qualified time, in cycles from the start of a RESET_PLL phase, when
  // pll_lock last rose at cycle last_high and then stayed high.
  function automatic int exp_rise(input int last_high);
    int s;
    s = last_high + 2;
    if (s < RST) s = RST;
    return s + STABLE;
  endfunction

  // Called on the first cycle of a RESET_PLL phase; stops on the first
  // cycle locked is seen high (rise = -1 if it never is).
  task automatic measure_lock(input int d_rise, input int g_at, input int g_len,
                              output int hi, output int rise, output int acks);
    hi = 0; rise = -1; acks = 0;
    for (int j = 0; j < ATTEMPT + 10 && rise < 0; j++) begin
      if (pll_reset) hi++;
      if (cfg_ack) acks++;
      if (locked) rise = j;
      if (j == d_rise) pll_lock = 1'b1;
      if (g_len > 0 && j == g_at) pll_lock = 1'b0;
      if (g_len > 0 && j == g_at + g_len) pll_lock = 1'b1;
      if (rise < 0) step();
    end
  endtask

  task automatic cfg_txn(input logic [3:0] p, input logic [3:0] q, input int win,
                         output int t_apply, output int t_ack, output int acks,
                         output int drops);
    cfg_req = 1'b1; cfg_psda = p; cfg_dutyda = q;
    t_apply = -1; t_ack = -1; acks = 0; drops = 0;
    for (int j = 1; j <= win; j++) begin
      step();
      if (t_apply < 0 && pll_psda === p && pll_dutyda === q) t_apply = j;
      if (cfg_ack) begin
        acks++;
        if (t_ack < 0) t_ack = j;
      end
      if (!sys_rst_n) drops++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, rise, acks, drops, t_apply, t_ack, d, g_at, g_len, m, t_drop, hold, t_fault;
    int t_r [1:3];
    logic [3:0] p, q;

    rst_n = 1'b0; pll_lock = 1'b0; cfg_req = 1'b0; cfg_psda = 4'h0;
    cfg_dutyda = 4'h0; relock_req = 1'b0;
    model_psda = 4'b0000; model_dutyda = 4'b1000;
    repeat (3) step();
    check_reset_values("por");

    // Startup
    rst_n = 1'b1;
    d = $urandom_range(5, 150);
    measure_lock(d, 0, 0, hi, rise, acks);
    check("startup_pll_reset_cycles", hi, RST);
    check("startup_lock_time", rise, exp_rise(d));
    check("startup_sys_rst_n", sys_rst_n, 1);
    check("startup_retry_cnt", retry_cnt, 0);
    check("startup_no_ack", acks, 0);

    // Glitchy lock during qualification
    relock_req = 1'b1; step(); relock_req = 1'b0;
    g_at  = $urandom_range(10, RST + STABLE - 12);
    g_len = $urandom_range(1, 5);
    measure_lock(0, g_at, g_len, hi, rise, acks);
    check("glitch_pll_reset_cycles", hi, RST);
    check("glitch_lock_time", rise, exp_rise(g_at + g_len));
    check("glitch_no_ack", acks, 0);

    // Adjust with the request held high after the ack
    cfg_txn(4'h5, 4'h6, 3 * SETTLE, t_apply, t_ack, acks, drops);
    model_psda = 4'h5; model_dutyda = 4'h6;
    check("adj_apply_latency", t_apply, 1);
    check("adj_ack_latency", t_ack, 1 + SETTLE);
    check("adj_ack_count_req_held", acks, 1);
    check("adj_sys_rst_n_drops", drops, 0);
    check("adj_psda", pll_psda, model_psda);
    check("adj_dutyda", pll_dutyda, model_dutyda);

    cfg_req = 1'b0; step();
    p = model_psda ^ 4'($urandom_range(1, 15));
    q = model_dutyda ^ 4'($urandom_range(1, 15));
    cfg_txn(p, q, 2 * SETTLE, t_apply, t_ack, acks, drops);
    model_psda = p; model_dutyda = q;
    check("adj2_apply_latency", t_apply, 1);
    check("adj2_ack_latency", t_ack, 1 + SETTLE);
    check("adj2_ack_count", acks, 1);
    check("adj2_sys_rst_n_drops", drops, 0);

    // Lock loss mid-settle
    cfg_req = 1'b0; step();
    p = model_psda ^ 4'($urandom_range(1, 15));
    q = model_dutyda ^ 4'($urandom_range(1, 15));
    cfg_req = 1'b1; cfg_psda = p; cfg_dutyda = q;
    m = $urandom_range(4, SETTLE - 8);
    t_drop = -1; acks = 0;
    for (int j = 1; j <= SETTLE + 10 && t_drop < 0; j++) begin
      step();
      if (cfg_ack) acks++;
      if (!sys_rst_n) t_drop = j;
      if (j == m) begin
        pll_lock = 1'b0;
        cfg_req  = 1'b0;
      end
    end
    model_psda = p; model_dutyda = q;
    check("abort_sys_rst_n_drop", t_drop, m + 3);
    check("abort_pll_reset", pll_reset, 1);
    check("abort_no_ack", acks, 0);
    check("abort_psda_kept", pll_psda, model_psda);
    check("abort_dutyda_kept", pll_dutyda, model_dutyda);
    d = $urandom_range(0, 40);
    measure_lock(d, 0, 0, hi, rise, acks);
    check("abort_relock_time", rise, exp_rise(d));
    check("abort_relock_pll_reset_cycles", hi, RST);
    check("abort_relock_no_ack", acks, 0);
    check("abort_relock_psda", pll_psda, model_psda);

    // relock_req together with cfg_req in RUN
    p = model_psda ^ 4'($urandom_range(1, 15));
    cfg_psda = p; cfg_dutyda = p; cfg_req = 1'b1; relock_req = 1'b1;
    step();
    relock_req = 1'b0; cfg_req = 1'b0;
    check("relock_cfg_pll_reset", pll_reset, 1);
    check("relock_cfg_sys_rst_n", sys_rst_n, 0);
    check("relock_cfg_psda_unchanged", pll_psda, model_psda);
    measure_lock(0, 0, 0, hi, rise, acks);
    check("relock_cfg_lock_time", rise, exp_rise(0));
    check("relock_cfg_no_ack", acks, 0);
    check("relock_cfg_dutyda_unchanged", pll_dutyda, model_dutyda);

    // Timeouts, retries and fault
    pll_lock = 1'b0; relock_req = 1'b1; step(); relock_req = 1'b0;
    t_r = '{-1, -1, -1}; t_fault = -1;
    check("timeout_start_retry", retry_cnt, 0);
    for (int j = 0; j <= 4 * ATTEMPT + 10 && t_fault < 0; j++) begin
      for (int k = 1; k <= 3; k++)
        if (t_r[k] < 0 && retry_cnt == 2'(k)) t_r[k] = j;
      if (fault) t_fault = j;
      if (t_fault < 0) step();
    end
    check("timeout_retry1_time", t_r[1], ATTEMPT);
    check("timeout_retry2_time", t_r[2], 2 * ATTEMPT);
    check("timeout_retry3_time", t_r[3], 3 * ATTEMPT);
    check("fault_time", t_fault, (RETRY + 1) * ATTEMPT);
    check("fault_pll_reset", pll_reset, 1);
    check("fault_sys_rst_n", sys_rst_n, 0);
    check("fault_locked", locked, 0);
    hold = $urandom_range(10, 50);
    repeat (hold) step();
    check("fault_held", fault, 1);
    d = $urandom_range(0, 60);
    relock_req = 1'b1; step(); relock_req = 1'b0;
    check("relock_clears_fault", fault, 0);
    check("relock_clears_retry", retry_cnt, 0);
    check("relock_pll_reset", pll_reset, 1);
    measure_lock(d, 0, 0, hi, rise, acks);
    check("after_fault_lock_time", rise, exp_rise(d));
    check("after_fault_pll_reset_cycles", hi, RST);

    // Async reset between clock edges while in RUN
    cfg_txn(4'hA, 4'h3, SETTLE + 4, t_apply, t_ack, acks, drops);
    cfg_req = 1'b0;
    check("pre_reset_psda", pll_psda, 4'hA);
    check("pre_reset_ack_count", acks, 1);
    check("pre_reset_locked", locked, 1);
    #1 rst_n = 1'b0;
    #0.5 check_reset_values("async_mid_run");
    #0.5 rst_n = 1'b1;
    measure_lock(0, 0, 0, hi, rise, acks);
    check("post_reset_lock_time", rise, exp_rise(0));
    check("post_reset_pll_reset_cycles", hi, RST);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the board rPLL: clocked from the free-running 27 MHz reference clock, ahead of the PLL.
- Sequences PLL reset, qualifies LOCK (async, synchronised and debounced), retries on lock timeout and drives the downstream system reset.
- Applies run-time PSDA/DUTYDA phase/duty changes through a req/ack handshake.

Parameters:
- RST_CYCLES, 16: cycles pll_reset held high per attempt.
- LOCK_STABLE, 1024: consecutive synced-lock-high cycles required before release.
- LOCK_TIMEOUT, 65536: cycles in WAIT_LOCK before an attempt fails.
- MAX_RETRY, 3: failed attempts tolerated before FAULT.
- SETTLE_CYCLES, 256: cycles held in ADJUST after applying new PSDA/DUTYDA.

Ports:
- clk  in  1  27 MHz reference clock.
- rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL LOCK, asynchronous to clk.
- pll_reset  out  1  PLL RESET, active high.
- pll_psda  out  4  PLL PSDA phase select.
- pll_dutyda  out  4  PLL DUTYDA duty select.
- cfg_req  in  1  level request to apply cfg_psda/cfg_dutyda.
- cfg_psda  in  4  requested phase.
- cfg_dutyda  in  4  requested duty.
- cfg_ack  out  1  one-cycle pulse when the new setting has settled.
- relock_req  in  1  one-cycle pulse: force a full restart and clear the fault.
- sys_rst_n  out  1  downstream reset, active low.
- locked  out  1  qualified lock.
- fault  out  1  retries exhausted.
- retry_cnt  out  2  failed attempts in the current sequence.

Behaviour:
- Reset (rst_n low, async):
  - Outputs: pll_reset=1, sys_rst_n=0, locked=0, fault=0, cfg_ack=0, retry_cnt=0, pll_psda=4'b0000, pll_dutyda=4'b1000.
  - State RESET_PLL; all counters 0.
- Lock input: pll_lock passes through a 2-flop synchroniser to lock_s. All decisions use lock_s (2-cycle input latency).
- Counters: width $clog2(max param + 1). No wrap: each counter clears on every state entry.
- RESET_PLL:
  - pll_reset=1, sys_rst_n=0, locked=0.
  - After RST_CYCLES cycles -> WAIT_LOCK, with pll_reset=0 on the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - lock_s high: stable counter increments. lock_s low: stable counter clears.
  - Stable count == LOCK_STABLE -> RUN.
  - Else timeout count == LOCK_TIMEOUT:
    - If retry_cnt == MAX_RETRY -> FAULT.
    - Otherwise retry_cnt++ -> RESET_PLL.
  - If stable and timeout conditions hit in the same cycle, RUN wins.
- RUN:
  - locked=1 and sys_rst_n=1, both registered, asserted on the first RUN cycle. retry_cnt clears on entry.
  - lock_s low -> RESET_PLL; locked=0 and sys_rst_n=0 on the next cycle. retry_cnt stays 0.
  - Accepted cfg_req -> ADJUST.
- ADJUST:
  - On entry, latch cfg_psda/cfg_dutyda into pll_psda/pll_dutyda (values visible the cycle after acceptance).
  - locked and sys_rst_n stay 1.
  - After SETTLE_CYCLES: cfg_ack=1 for exactly one cycle -> RUN.
  - lock_s low in ADJUST -> RESET_PLL with no ack; the latched psda/dutyda are retained.
- FAULT:
  - pll_reset=1, sys_rst_n=0, locked=0, fault=1.
  - Held until relock_req.
- Handshake rules:
  - cfg_req is sampled only in RUN. In other states it stays pending while high.
  - A new transaction is accepted only after cfg_req has been low for at least one cycle since the last ack (req_armed flag, set at reset).
  - psda/dutyda are never changed outside ADJUST entry.
- relock_req, any state:
  - Next state RESET_PLL; fault=0, retry_cnt=0, cfg transaction aborted without ack.
  - Priority: relock_req > lock loss > cfg_req.
- Mid-operation rst_n assertion returns to the reset values immediately, including psda/dutyda defaults.

Test Plan:
- Startup: release rst_n; pll_lock rises 100 cycles later and stays high -> pll_reset high 16 cycles; sys_rst_n and locked rise 1024+2 cycles after pll_lock (±1); retry_cnt=0.
- Glitchy lock: pll_lock high 500 cycles, low 3, then high -> stable count restarts; sys_rst_n rises 1024 cycles after the final rise (+2 sync).
- Timeout/fault: pll_lock held low -> retry_cnt steps 1, 2, 3 after successive 65536-cycle timeouts; 4th timeout -> fault=1, pll_reset=1; relock_req pulse -> fault=0, retry_cnt=0, new RESET_PLL.
- Adjust: in RUN, cfg_req=1, cfg_psda=4'h5, cfg_dutyda=4'h6 -> pll_psda=5, pll_dutyda=6 next cycle; cfg_ack one-cycle pulse 256 cycles later; sys_rst_n stays 1. Req held high after ack -> no second ack until req drops.
- Lock loss during ADJUST plus simultaneous relock_req/cfg_req: drop pll_lock mid-settle -> no cfg_ack, sys_rst_n=0 within 3 cycles, pll_psda stays 5. relock_req together with cfg_req in RUN -> RESET_PLL, no ADJUST.
- Async reset mid-RUN: rst_n low for 1 ns between edges -> all outputs at reset values immediately; pll_dutyda=4'b1000.
